udp_sample_framer: RTL

UDP_SAMPLE_FRAMER -- requirements
Module: udp_sample_framer

---
 rtl/udp_sample_framer_if.sv | 22 ++
 rtl/udp_sample_framer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/udp_sample_framer_if.sv
// Byte-stream ports of udp_sample_framer: the sample input handshake and the MAC transmit handshake.
interface udp_sample_framer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_sop;
    logic       tx_eop;
    logic       tx_err;
    logic       tx_wren;
    logic       tx_rdy;

    modport master (
        input  in_data, in_valid, tx_rdy,
        output in_ready, tx_data, tx_sop, tx_eop, tx_err, tx_wren
    );

    modport slave (
        output in_data, in_valid, tx_rdy,
        input  in_ready, tx_data, tx_sop, tx_eop, tx_err, tx_wren
    );
endinterface

// File: rtl/udp_sample_framer.sv
// Wraps a fixed-size sample byte stream into Ethernet/IPv4/UDP frames for a byte-wide MAC.
// Define UDP_FRAMER_SEQNUM_EN to prefix each payload with a 32-bit big-endian sequence number.
module udp_sample_framer #(
    parameter int          PAYLOAD_BYTES = 1024,
    parameter logic [47:0] SRC_MAC       = 48'h02_00_00_00_00_01,
    parameter logic [47:0] DST_MAC       = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP        = 32'hC0A8010A,
    parameter logic [31:0] DST_IP        = 32'hC0A80101,
    parameter logic [15:0] SRC_PORT      = 16'd5000,
    parameter logic [15:0] DST_PORT      = 16'd5000
) (
    input  logic                tx_clk,
    input  logic                rst,
    udp_sample_framer_if.master bus,
    output logic [15:0]         frame_count
);

`ifdef UDP_FRAMER_SEQNUM_EN
    localparam int SEQ_BYTES = 4;
`else
    localparam int SEQ_BYTES = 0;
`endif
    localparam int               HDR_BYTES    = 42 + SEQ_BYTES;
    localparam int               UDP_PAYLOAD  = PAYLOAD_BYTES + SEQ_BYTES;
    localparam logic [15:0]      IP_TOTAL_LEN = 16'(28 + UDP_PAYLOAD);
    localparam logic [15:0]      UDP_LEN      = 16'(8 + UDP_PAYLOAD);
    localparam logic [5:0]       LAST_HDR     = 6'(HDR_BYTES - 1);
    localparam int               CNT_W        = $clog2(PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] LAST_PAY     = CNT_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CSUM, HEADER, PAYLOAD} state_t;

    state_t                   state;
    logic [5:0]               hdr_idx;
    logic [CNT_W-1:0]         pay_cnt;
    logic                     csum_phase;
    logic [19:0]              csum_acc;
    logic [15:0]              checksum;
    logic [16:0]              fold1;
    logic [15:0]              fold2;
    logic [5:0]               rev_idx;
    logic [HDR_BYTES-1:0][7:0] hdr_vec;
    logic [41:0][7:0]         base_hdr;

    // The ip_id of the frame being built is the number of frames already completed.
    function automatic logic [19:0] header_word_sum(input logic [15:0] ip_id);
        return 20'(16'h4500) + 20'(IP_TOTAL_LEN) + 20'(ip_id) + 20'(16'h4000)
             + 20'(16'h4011) + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
             + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    endfunction

    always_comb begin
        fold1 = 17'(csum_acc[15:0]) + 17'(csum_acc[19:16]);
        fold2 = fold1[15:0] + 16'(fold1[16]);
    end

    assign base_hdr = {DST_MAC, SRC_MAC, 16'h0800,
                       16'h4500, IP_TOTAL_LEN, frame_count, 16'h4000, 16'h4011, checksum,
                       SRC_IP, DST_IP,
                       SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

`ifdef UDP_FRAMER_SEQNUM_EN
    logic [31:0] seq_num;
    assign hdr_vec = {base_hdr, seq_num};
`else
    assign hdr_vec = base_hdr;
`endif

    // Byte 0 of the header sits in the most significant slot of the packed vector.
    assign rev_idx = LAST_HDR - hdr_idx;

    // rst gates the strobes so nothing is offered while a frame is being abandoned.
    always_comb begin
        bus.tx_data  = 8'h00;
        bus.tx_sop   = 1'b0;
        bus.tx_eop   = 1'b0;
        bus.tx_wren  = 1'b0;
        bus.in_ready = 1'b0;
        if (!rst) begin
            case (state)
                HEADER: begin
                    bus.tx_data = hdr_vec[rev_idx];
                    bus.tx_sop  = (hdr_idx == 6'd0);
                    bus.tx_wren = 1'b1;
                end
                PAYLOAD: begin
                    bus.tx_data  = bus.in_data;
                    bus.tx_eop   = (pay_cnt == LAST_PAY);
                    bus.tx_wren  = bus.in_valid;
                    bus.in_ready = bus.tx_rdy;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_err = 1'b0;

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state       <= IDLE;
            hdr_idx     <= 6'd0;
            pay_cnt     <= '0;
            csum_phase  <= 1'b0;
            csum_acc    <= 20'd0;
            checksum    <= 16'd0;
            frame_count <= 16'd0;
`ifdef UDP_FRAMER_SEQNUM_EN
            seq_num     <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state      <= CSUM;
                        csum_phase <= 1'b0;
                    end
                end
                // First cycle sums the header words, second folds and inverts.
                CSUM: begin
                    if (!csum_phase) begin
                        csum_acc   <= header_word_sum(frame_count);
                        csum_phase <= 1'b1;
                    end else begin
                        checksum   <= ~fold2;
                        csum_phase <= 1'b0;
                        hdr_idx    <= 6'd0;
                        state      <= HEADER;
                    end
                end
                HEADER: begin
                    if (bus.tx_rdy) begin
                        if (hdr_idx == LAST_HDR) begin
                            hdr_idx <= 6'd0;
                            pay_cnt <= '0;
                            state   <= PAYLOAD;
                        end else begin
                            hdr_idx <= hdr_idx + 6'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.in_valid && bus.tx_rdy) begin
                        if (pay_cnt == LAST_PAY) begin
                            pay_cnt     <= '0;
                            state       <= IDLE;
                            frame_count <= frame_count + 16'd1;
`ifdef UDP_FRAMER_SEQNUM_EN
                            seq_num     <= seq_num + 32'd1;
`endif
                        end else begin
                            pay_cnt <= pay_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
